// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the RV32I core: writeback-select encodings, load and
// store funct3 codes, access-size codes (funct3[1:0]) and the MEM-stage
// handshake state type.
// ---------------------------------------------------------------------------
package riscv_pkg;

    // Writeback source select
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    // Load funct3
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Access size, taken from funct3[1:0] for both loads and stores
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// ---------------------------------------------------------------------------
// LoadAlign
// Purely combinational lane extractor. It picks the byte or halfword that is
// addressed by offset out of a 32-bit word and then sign- or zero-extends it
// according to funct3. Any funct3 other than LB/LBU/LH/LHU passes the word
// through unchanged. A halfword is selected by offset[1] only.
//   rdata  in  32  source word
//   offset in  2   byte offset within the word
//   funct3 in  3   size / signedness
//   data   out 32  extended result
// ---------------------------------------------------------------------------
module LoadAlign
    import riscv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (offset)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
    end

    assign half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        data = rdata;
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {24'd0, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
// Combined MEM/WB stage. It runs loads/stores over a req/ack data-memory
// port with wait states, formats load data and registers the writeback
// triple (RegWriteWB_o, writeRegAddr_o, WD3_o) for the register file.
// While an access is outstanding stall_o freezes the upstream stages, and the
// MEM/WB register loads a bubble so that no writeback is duplicated.
//
// Optional feature macro: MISALIGN_CHECK_EN
//   defined   : misaligned LH/LHU/SH/LW/SW issue no request and no writeback;
//               misalign_o pulses for one cycle in the WB slot.
//   undefined : the low address bits that do not apply are ignored; misalign_o = 0.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   RegWrite_i .. funct3_i   EX/MEM control and data
//   dmem_*                   data-memory request/response port
//   stall_o                  to the hazard unit
//   RegWriteWB_o, writeRegAddr_o, WD3_o   register-file write port
//   misalign_o               misaligned-access pulse
// ---------------------------------------------------------------------------
module mem_wb_stage
    import riscv_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        RegWrite_i,
    input  logic [1:0]  WriteSrc_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] ALUout_i,
    input  logic [31:0] writeData_i,
    input  logic [31:0] ImmOp_i,
    input  logic [31:0] pcPlus4_i,
    input  logic [4:0]  rd_i,
    input  logic [2:0]  funct3_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic        RegWriteWB_o,
    output logic [4:0]  writeRegAddr_o,
    output logic [31:0] WD3_o,
    output logic        misalign_o
);

    mem_state_t  state_reg;
    logic [1:0]  offset;
    logic [1:0]  size;
    logic        mem_op;
    logic        misaligned;
    logic        access;
    logic        wb_en;
    logic [31:0] load_data;
    logic [31:0] store_src;
    logic [31:0] wb_data;

    assign offset = ALUout_i[1:0];
    assign size   = funct3_i[1:0];
    assign mem_op = MemRead_i | MemWrite_i;

`ifdef MISALIGN_CHECK_EN
    always_comb begin
        misaligned = 1'b0;
        case (size)
            SZ_HALF: misaligned = mem_op & offset[0];
            SZ_WORD: misaligned = mem_op & (offset != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    assign access = mem_op & ~misaligned;

    // Request is gated by reset so an access in flight is dropped the moment
    // reset asserts. In WAIT the inputs are frozen, so access is still high.
    assign dmem_req_o  = rst_ni & ((state_reg == WAIT) | access);
    assign stall_o     = dmem_req_o & ~dmem_ack_i;
    assign dmem_we_o   = MemWrite_i;
    assign dmem_addr_o = {ALUout_i[31:2], 2'b00};

    LoadAlign u_load_align (
        .rdata  (dmem_rdata_i),
        .offset (offset),
        .funct3 (funct3_i),
        .data   (load_data)
    );

    // Same extractor, unsigned at offset 0: isolates the store byte/halfword
    LoadAlign u_store_lane (
        .rdata  (writeData_i),
        .offset (2'b00),
        .funct3 ({1'b1, size}),
        .data   (store_src)
    );

    always_comb begin
        dmem_be_o    = 4'b1111;
        dmem_wdata_o = store_src;
        if (MemWrite_i) begin
            case (size)
                SZ_BYTE: begin
                    dmem_be_o    = 4'b0001 << offset;
                    dmem_wdata_o = {4{store_src[7:0]}};
                end
                SZ_HALF: begin
                    dmem_be_o    = offset[1] ? 4'b1100 : 4'b0011;
                    dmem_wdata_o = {2{store_src[15:0]}};
                end
                default: begin
                    dmem_be_o    = 4'b1111;
                    dmem_wdata_o = store_src;
                end
            endcase
        end
    end

    always_comb begin
        wb_data = ALUout_i;
        case (WriteSrc_i)
            WB_MEM:  wb_data = load_data;
            WB_PC4:  wb_data = pcPlus4_i;
            WB_IMM:  wb_data = ImmOp_i;
            default: wb_data = ALUout_i;
        endcase
    end

    // When not stalled, any memory access has completed this cycle.
    // Stores (including read+write) and misaligned accesses never write back.
    assign wb_en = RegWrite_i & (rd_i != 5'd0) & ~MemWrite_i & ~misaligned;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= IDLE;
            RegWriteWB_o   <= 1'b0;
            writeRegAddr_o <= 5'd0;
            WD3_o          <= 32'd0;
        end else begin
            case (state_reg)
                IDLE:    if (access && !dmem_ack_i) state_reg <= WAIT;
                WAIT:    if (dmem_ack_i) state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase

            if (stall_o) begin
                RegWriteWB_o   <= 1'b0;
                writeRegAddr_o <= 5'd0;
                WD3_o          <= 32'd0;
            end else begin
                RegWriteWB_o   <= wb_en;
                writeRegAddr_o <= rd_i;
                WD3_o          <= wb_data;
            end
        end
    end

`ifdef MISALIGN_CHECK_EN
    // A misaligned access never stalls, so it always lands in the next WB slot
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            misalign_o <= 1'b0;
        end else begin
            misalign_o <= misaligned;
        end
    end
`else
    assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_stage
// Directed and randomized stimulus for mem_wb_stage, checked against a
// behavioural model of the load/store and writeback rules. Honours
// MISALIGN_CHECK_EN when the bench is built with it.
// ---------------------------------------------------------------------------
module tb_mem_wb_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        RegWrite_i;
    logic [1:0]  WriteSrc_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] ALUout_i;
    logic [31:0] writeData_i;
    logic [31:0] ImmOp_i;
    logic [31:0] pcPlus4_i;
    logic [4:0]  rd_i;
    logic [2:0]  funct3_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;
    logic        stall_o;
    logic        RegWriteWB_o;
    logic [4:0]  writeRegAddr_o;
    logic [31:0] WD3_o;
    logic        misalign_o;

    int checks = 0;
    int errors = 0;

    mem_wb_stage dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .RegWrite_i     (RegWrite_i),
        .WriteSrc_i     (WriteSrc_i),
        .MemRead_i      (MemRead_i),
        .MemWrite_i     (MemWrite_i),
        .ALUout_i       (ALUout_i),
        .writeData_i    (writeData_i),
        .ImmOp_i        (ImmOp_i),
        .pcPlus4_i      (pcPlus4_i),
        .rd_i           (rd_i),
        .funct3_i       (funct3_i),
        .dmem_req_o     (dmem_req_o),
        .dmem_we_o      (dmem_we_o),
        .dmem_addr_o    (dmem_addr_o),
        .dmem_be_o      (dmem_be_o),
        .dmem_wdata_o   (dmem_wdata_o),
        .dmem_ack_i     (dmem_ack_i),
        .dmem_rdata_i   (dmem_rdata_i),
        .stall_o        (stall_o),
        .RegWriteWB_o   (RegWriteWB_o),
        .writeRegAddr_o (writeRegAddr_o),
        .WD3_o          (WD3_o),
        .misalign_o     (misalign_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // ---- reference model -------------------------------------------------
    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] a,
                                               input logic [2:0] f3);
        logic [31:0] b;
        logic [31:0] h;
        b = (word >> (8 * a)) & 32'hFF;
        h = (word >> (16 * (a / 2))) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'b101:  return h;
            default: return word;
        endcase
    endfunction

    function automatic logic model_misaligned(input logic mem, input logic [1:0] a,
                                              input logic [2:0] f3);
`ifdef MISALIGN_CHECK_EN
        if (!mem) return 1'b0;
        if (f3[1:0] == 2'b01) return a % 2 != 0;
        if (f3[1:0] == 2'b10) return a != 0;
        return 1'b0;
`else
        return 1'b0 & mem & a[0] & f3[0];
`endif
    endfunction

    // One EX/MEM transaction: starts and ends 1 time unit after a rising edge
    task automatic run_op(input string name, input logic rw, input logic [1:0] ws,
                          input logic mr, input logic mw, input logic [31:0] alu,
                          input logic [31:0] wd, input logic [4:0] rd, input logic [2:0] f3,
                          input logic [31:0] rdata, input int waits_in);
        logic        mem;
        logic        mis;
        logic        acc;
        logic        exp_we;
        logic [31:0] exp_wd3;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [1:0]  a;
        int          waits;

        imm = $urandom;
        pc4 = $urandom;
        a   = alu[1:0];
        mem = mr | mw;
        mis = model_misaligned(mem, a, f3);
        acc = mem & !mis;
        waits = acc ? waits_in : 0;

        exp_we = rw && (rd != 0) && !mw && !mis;
        case (ws)
            2'b00:   exp_wd3 = alu;
            2'b01:   exp_wd3 = model_load(rdata, a, f3);
            2'b10:   exp_wd3 = pc4;
            default: exp_wd3 = imm;
        endcase
        exp_be    = 4'hF;
        exp_wdata = wd;
        if (mw) begin
            case (f3[1:0])
                2'b00: begin exp_be = 4'(1 << a);           exp_wdata = (wd & 32'hFF)   * 32'h0101_0101; end
                2'b01: begin exp_be = 4'(3 << (2 * (a / 2))); exp_wdata = (wd & 32'hFFFF) * 32'h0001_0001; end
                default: begin exp_be = 4'hF;               exp_wdata = wd; end
            endcase
        end

        RegWrite_i  = rw;
        WriteSrc_i  = ws;
        MemRead_i   = mr;
        MemWrite_i  = mw;
        ALUout_i    = alu;
        writeData_i = wd;
        ImmOp_i     = imm;
        pcPlus4_i   = pc4;
        rd_i        = rd;
        funct3_i    = f3;

        for (int k = 0; k < waits; k++) begin
            dmem_ack_i   = 1'b0;
            dmem_rdata_i = $urandom;
            #4;
            check({name, ".stall_wait"}, 32'(stall_o), 32'd1);
            check({name, ".req_wait"}, 32'(dmem_req_o), 32'd1);
            @(posedge clk_i);
            #1;
            check({name, ".bubble"}, 32'(RegWriteWB_o), 32'd0);
        end

        // Ack with no request outstanding must be ignored, so drive it randomly
        dmem_ack_i   = acc ? 1'b1 : 1'($urandom_range(0, 1));
        dmem_rdata_i = rdata;
        #4;
        check({name, ".stall"}, 32'(stall_o), 32'd0);
        check({name, ".req"}, 32'(dmem_req_o), 32'(acc));
        if (acc) begin
            check({name, ".we"}, 32'(dmem_we_o), 32'(mw));
            check({name, ".addr"}, dmem_addr_o, alu & 32'hFFFF_FFFC);
            check({name, ".be"}, 32'(dmem_be_o), 32'(exp_be));
            if (mw) check({name, ".wdata"}, dmem_wdata_o, exp_wdata);
        end
        @(posedge clk_i);
        #1;
        dmem_ack_i = 1'b0;
        check({name, ".regwrite"}, 32'(RegWriteWB_o), 32'(exp_we));
        if (exp_we) begin
            check({name, ".rd"}, 32'(writeRegAddr_o), 32'(rd));
            check({name, ".wd3"}, WD3_o, exp_wd3);
        end
        check({name, ".misalign"}, 32'(misalign_o), 32'(mis));
        $display("op %s alu=%08h f3=%0d mr=%0d mw=%0d waits=%0d -> we=%0d wd3=%08h",
                 name, alu, f3, mr, mw, waits, RegWriteWB_o, WD3_o);
    endtask

    initial begin
        logic [2:0] load_f3 [5];
        logic [2:0] store_f3 [3];
        load_f3  = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        store_f3 = '{3'b000, 3'b001, 3'b010};

        rst_ni = 1'b0;
        RegWrite_i = 1'b0; WriteSrc_i = 2'b00; MemRead_i = 1'b1; MemWrite_i = 1'b0;
        ALUout_i = 32'h100; writeData_i = '0; ImmOp_i = '0; pcPlus4_i = '0;
        rd_i = '0; funct3_i = 3'b010; dmem_ack_i = 1'b0; dmem_rdata_i = '0;

        // Reset: outputs zero, request suppressed even with a load presented
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        check("reset.regwrite", 32'(RegWriteWB_o), 32'd0);
        check("reset.rd", 32'(writeRegAddr_o), 32'd0);
        check("reset.wd3", WD3_o, 32'd0);
        check("reset.misalign", 32'(misalign_o), 32'd0);
        check("reset.req", 32'(dmem_req_o), 32'd0);
        check("reset.stall", 32'(stall_o), 32'd0);
        $display("reset checked");
        MemRead_i = 1'b0;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Directed cases
        run_op("alu_rd5", 1'b1, 2'b00, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd5, 3'b000, 32'h0, 0);
        run_op("lb_wait3", 1'b1, 2'b01, 1'b1, 1'b0, 32'h103, 32'h0, 5'd7, 3'b000, 32'h80FF_0000, 3);
        run_op("sh_0x202", 1'b1, 2'b00, 1'b0, 1'b1, 32'h202, 32'hABCD, 5'd9, 3'b001, 32'h0, 0);
        run_op("lw_b2b", 1'b1, 2'b01, 1'b1, 1'b0, 32'h400, 32'h0, 5'd10, 3'b010, 32'hDEAD_BEEF, 0);
        run_op("lbu_b2b", 1'b1, 2'b01, 1'b1, 1'b0, 32'h405, 32'h0, 5'd11, 3'b100, 32'h1234_F678, 0);
        run_op("lw_mis", 1'b1, 2'b01, 1'b1, 1'b0, 32'h102, 32'h0, 5'd12, 3'b010, 32'hCAFE_F00D, 0);
        run_op("rd0_load", 1'b1, 2'b01, 1'b1, 1'b0, 32'h500, 32'h0, 5'd0, 3'b010, 32'h1111_2222, 1);
        run_op("rd_wr_both", 1'b1, 2'b01, 1'b1, 1'b1, 32'h601, 32'h5A, 5'd13, 3'b000, 32'h0, 2);

        // Reset asserted while waiting on an LW
        RegWrite_i = 1'b1; WriteSrc_i = 2'b01; MemRead_i = 1'b1; MemWrite_i = 1'b0;
        ALUout_i = 32'h700; rd_i = 5'd14; funct3_i = 3'b010; dmem_ack_i = 1'b0;
        #4;
        check("rstwait.stall", 32'(stall_o), 32'd1);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        check("rstwait.req", 32'(dmem_req_o), 32'd0);
        check("rstwait.stall_off", 32'(stall_o), 32'd0);
        check("rstwait.regwrite", 32'(RegWriteWB_o), 32'd0);
        check("rstwait.wd3", WD3_o, 32'd0);
        check("rstwait.rd", 32'(writeRegAddr_o), 32'd0);
        RegWrite_i = 1'b0; MemRead_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        dmem_ack_i = 1'b1;
        dmem_rdata_i = 32'h9999_9999;
        #4;
        check("lateack.req", 32'(dmem_req_o), 32'd0);
        @(posedge clk_i);
        #1;
        dmem_ack_i = 1'b0;
        check("lateack.regwrite", 32'(RegWriteWB_o), 32'd0);
        $display("reset during wait checked");

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            int          kind;
            logic        mr;
            logic        mw;
            logic [2:0]  f3;
            kind = $urandom_range(0, 9);
            mr = 1'b0; mw = 1'b0;
            f3 = 3'($urandom_range(0, 7));
            if (kind >= 2 && kind <= 5) begin
                mr = 1'b1; f3 = load_f3[$urandom_range(0, 4)];
            end else if (kind >= 6) begin
                mw = 1'b1; mr = (kind == 9); f3 = store_f3[$urandom_range(0, 2)];
            end
            run_op("rand", 1'($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), mr, mw,
                   $urandom, $urandom, 5'($urandom_range(0, 31)), f3, $urandom,
                   $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Combined MEM/WB pipeline stage of the five-stage RV32I core. It takes EX/MEM control and data, runs loads and stores over a req/ack data-memory port with wait-state support, and formats load data. It registers the result into the MEM/WB register and drives the writeback triple back into the decode stage's register-file write port. While a memory access is outstanding it raises a stall to the hazard detection unit.

## Interface
Parameters
- none; all widths are fixed at RV32 (XLEN 32, 5-bit register addresses).

Ports
- clk_i  in  1  core clock; all state is updated on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- RegWrite_i  in  1  EX/MEM register-write enable.
- WriteSrc_i  in  2  writeback select: 00 ALU, 01 load data, 10 pcPlus4, 11 ImmOp.
- MemRead_i  in  1  load.
- MemWrite_i  in  1  store.
- ALUout_i  in  32  ALU result; also the memory address.
- writeData_i  in  32  store data (rs2).
- ImmOp_i  in  32  immediate, used for LUI writeback.
- pcPlus4_i  in  32  link value for JAL/JALR.
- rd_i  in  5  destination register.
- funct3_i  in  3  load/store size and signedness.
- dmem_req_o  out  1  memory request; held until acknowledged.
- dmem_we_o  out  1  1 = store.
- dmem_addr_o  out  32  word-aligned address ({ALUout_i[31:2],2'b00}).
- dmem_be_o  out  4  byte enables.
- dmem_wdata_o  out  32  lane-aligned store data.
- dmem_ack_i  in  1  request complete; rdata valid in the same cycle for loads.
- dmem_rdata_i  in  32  read word.
- stall_o  out  1  to the hazard unit; freezes IF, ID, EX and the EX/MEM inputs.
- RegWriteWB_o  out  1  register-file write enable (feeds RegWriteWB_i of decode).
- writeRegAddr_o  out  5  write address.
- WD3_o  out  32  write data.
- misalign_o  out  1  misaligned-access pulse (macro-dependent).

## Operation
- FSM states: IDLE and WAIT.
- IDLE, no memory operation: pass-through. The MEM/WB register loads the selected result at the next edge.
- IDLE, memory operation, dmem_ack_i=1 in the same cycle: zero-wait completion. There is no stall. The load result is captured at the edge.
- IDLE, memory operation, dmem_ack_i=0: stall_o=1 and the FSM moves to WAIT.
- WAIT: dmem_req_o stays at 1 and stall_o stays at 1. The request fields stay stable because the upstream stages are frozen. When dmem_ack_i=1, stall_o drops in that cycle, the result is captured and the FSM returns to IDLE.
- Stall cycles: the MEM/WB register loads a bubble (RegWriteWB_o=0) so that no writeback is duplicated.
- MemRead_i and MemWrite_i both 1: treated as a store.
- rd_i=0: RegWriteWB_o is forced to 0.
- A store never writes back, whatever the value of RegWrite_i.
- Loads, indexed by offset a=ALUout_i[1:0]:
  - LB: sign-extend byte a.
  - LBU: zero-extend byte a.
  - LH: sign-extend halfword a[1].
  - LHU: zero-extend halfword a[1].
  - LW: full word.
- Stores:
  - SB: be=4'b0001<<a, wdata = the byte replicated into all four lanes.
  - SH: be=0011 or 1100 selected by a[1], wdata = the halfword replicated.
  - SW: be=1111.
- Loads drive be=1111.
- dmem_ack_i while dmem_req_o=0 is ignored.

## Timing
- Reset: FSM goes to IDLE, and RegWriteWB_o, writeRegAddr_o, WD3_o, misalign_o are all 0.
- dmem_req_o and stall_o are combinational from the state and inputs, so both are 0 under reset.
- Reset during WAIT: the request is dropped immediately and no writeback occurs.
- Latency from EX/MEM input to writeback outputs: 1 cycle plus the number of wait cycles.
- Register-file write timing: the register file writes on the edge after the WB outputs become valid.
- A new memory operation may be presented in the cycle after an acknowledge. There are no bubble cycles between back-to-back accesses.

## Configuration
- MISALIGN_CHECK_EN defined:
  - An access is misaligned when it is LH/LHU/SH with a[0]=1, or LW/SW with a≠0.
  - A misaligned access issues no request, causes no stall and writes nothing back.
  - misalign_o pulses high for one cycle, registered and aligned with the WB slot.
- MISALIGN_CHECK_EN undefined:
  - The offending low address bits are ignored, so a halfword uses a[1] and a word ignores a.
  - misalign_o is tied to 0.

## Structure
- Shared package riscv_pkg holds:
  - the WriteSrc encodings;
  - the funct3 constants (F3_LB/LH/LW/LBU/LHU, F3_SB/SH/SW);
  - the mem_state_t enum {IDLE, WAIT}.
- One combinational sub-module, LoadAlign (rdata, offset, funct3 → extended word). It is reused by the store lane logic for symmetry.

## Test plan
- ALU write, rd=5, ALUout=0x1234, WriteSrc=00, no memory operation → next cycle RegWriteWB_o=1, writeRegAddr_o=5, WD3_o=0x1234, stall_o never set.
- LB, addr 0x103, rdata=0x80FF_0000, ack after 3 wait cycles:
  - stall_o high for 3 cycles, bubbles on the WB outputs;
  - WD3_o=0xFFFF_FF80 after the ack.
- SH, addr 0x202, writeData=0xABCD, zero-wait ack → be=1100, wdata=0xABCD_ABCD, RegWriteWB_o=0.
- Back-to-back LW then LBU, each acked immediately → two consecutive writebacks, no stall.
- Reset asserted in WAIT of an LW → dmem_req_o=0 at once, WB outputs 0, a late ack ignored.
- Misaligned LW to 0x102:
  - with MISALIGN_CHECK_EN: no request, misalign_o=1 for one cycle, no write;
  - without it: request at 0x100 with be=1111.
